// File: rtl/pipe_stall_ctrl.sv
// -----------------------------------------------------------------------------
// pipe_stall_ctrl
//
// This block controls the pipeline stalls. It drives the write enables of the
// PC, F/D, D/E, E/M and M/W pipeline registers. It also drives the F/D flush
// select and the D/E bubble select.
//
// In the RUN state it resolves these hazards in priority order, highest first:
//   - D-cache miss
//   - I-cache miss
//   - taken branch
//   - load-use
//
// A cache miss moves the block into a refill state (ISTALL or DSTALL). The
// refill state is timed by a latency counter. A 32-bit (PERF_W) counter
// saturates at all-ones and counts the cycles in which the PC was not written.
//
// Ports
//   clk           pipeline clock, rising edge
//   reset         asynchronous, active-low reset
//   icache_miss   F-stage fetch missed (held by the cache until fill_done)
//   dcache_miss   M-stage access missed (held by the cache until fill_done)
//   load_use      D-stage instruction needs the result of a load now in E
//   branch_taken  E-stage branch/jump resolved taken
//   wr_pc..wr_mw  pipeline register write enables
//   flush_fd      F/D loads a NOP
//   bubble_de     D/E loads a NOP
//   mem_req       refill in progress
//   mem_is_data   refill targets the D-cache (0 = I-cache)
//   fill_done     single-cycle pulse in the last refill cycle
//   stall_cycles  saturating count of cycles with wr_pc = 0
// -----------------------------------------------------------------------------
module pipe_stall_ctrl #(
    parameter int MEM_LATENCY = 5,
    parameter int CNT_W       = 8,
    parameter int PERF_W      = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              icache_miss,
    input  logic              dcache_miss,
    input  logic              load_use,
    input  logic              branch_taken,
    output logic              wr_pc,
    output logic              wr_fd,
    output logic              wr_de,
    output logic              wr_em,
    output logic              wr_mw,
    output logic              flush_fd,
    output logic              bubble_de,
    output logic              mem_req,
    output logic              mem_is_data,
    output logic              fill_done,
    output logic [PERF_W-1:0] stall_cycles
);

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        ISTALL = 2'd1,
        DSTALL = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MEM_LATENCY - 1);

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              pend_q, pend_d;
    logic [PERF_W-1:0] stall_q, stall_d;

    // Ungated combinational outputs. Bit order is {pc, fd, de, em, mw}.
    logic [4:0] wr_v;
    logic       flush_v, bubble_v, mreq_v, mdata_v, fdone_v;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        pend_d   = pend_q;
        wr_v     = 5'b11111;
        flush_v  = 1'b0;
        bubble_v = 1'b0;
        mreq_v   = 1'b0;
        mdata_v  = 1'b0;
        fdone_v  = 1'b0;

        case (state_q)
            RUN: begin
                if (dcache_miss) begin
                    wr_v    = 5'b00000;
                    state_d = DSTALL;
                    cnt_d   = CNT_LOAD;
                    pend_d  = 1'b0;
                end else if (icache_miss) begin
                    wr_v    = 5'b00000;
                    state_d = ISTALL;
                    cnt_d   = CNT_LOAD;
                end else if (branch_taken) begin
                    // The load-use victim is the instruction being squashed,
                    // so a simultaneous load_use needs no stall.
                    flush_v  = 1'b1;
                    bubble_v = 1'b1;
                end else if (load_use) begin
                    // Hold PC and F/D. Insert a bubble into E. Let the older
                    // instructions drain.
                    wr_v     = 5'b00111;
                    bubble_v = 1'b1;
                end
            end

            ISTALL: begin
                wr_v   = 5'b00000;
                mreq_v = 1'b1;
                // Remember a D-cache miss raised while the I-cache refill
                // owns memory, so that the D refill follows back to back.
                if (dcache_miss) begin
                    pend_d = 1'b1;
                end
                if (cnt_q == '0) begin
                    fdone_v = 1'b1;
                    if (pend_q || dcache_miss) begin
                        state_d = DSTALL;
                        cnt_d   = CNT_LOAD;
                        pend_d  = 1'b0;
                    end else begin
                        state_d = RUN;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end

            DSTALL: begin
                wr_v    = 5'b00000;
                mreq_v  = 1'b1;
                mdata_v = 1'b1;
                if (cnt_q == '0) begin
                    fdone_v = 1'b1;
                    state_d = RUN;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end

            default: begin
                wr_v    = 5'b00000;
                state_d = RUN;
            end
        endcase
    end

    // Saturating performance counter of cycles in which the PC is frozen.
    always_comb begin
        stall_d = stall_q;
        if (!wr_v[4] && (stall_q != {PERF_W{1'b1}})) begin
            stall_d = stall_q + PERF_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= RUN;
            cnt_q   <= '0;
            pend_q  <= 1'b0;
            stall_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pend_q  <= pend_d;
            stall_q <= stall_d;
        end
    end

    // The reset level gates the outputs directly. This forces them low
    // immediately, independent of the clock.
    assign wr_pc        = reset & wr_v[4];
    assign wr_fd        = reset & wr_v[3];
    assign wr_de        = reset & wr_v[2];
    assign wr_em        = reset & wr_v[1];
    assign wr_mw        = reset & wr_v[0];
    assign flush_fd     = reset & flush_v;
    assign bubble_de    = reset & bubble_v;
    assign mem_req      = reset & mreq_v;
    assign mem_is_data  = reset & mdata_v;
    assign fill_done    = reset & fdone_v;
    assign stall_cycles = stall_q;

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
module tb_pipe_stall_ctrl;

    // Expected response for one cycle on one DUT instance.
    typedef struct packed {
        logic [3:0]  ph;
        logic [1:0]  d;
        logic [4:0]  wr;
        logic        fl;
        logic        bu;
        logic        mr;
        logic        md;
        logic        fdn;
        logic [31:0] sc;
    } exp_t;

    localparam logic [4:0] NORM = 5'b11111;
    localparam logic [4:0] FROZ = 5'b00000;
    localparam logic [4:0] LDU  = 5'b00111;

    logic       clk = 1'b0;
    logic [2:0] rst_v = 3'b000;
    logic       icm = 1'b0, dcm = 1'b0, lu = 1'b0, bt = 1'b0;
    logic [2:0] wr_pc, wr_fd, wr_de, wr_em, wr_mw, flush_fd, bubble_de;
    logic [2:0] mem_req, mem_is_data, fill_done;
    logic [31:0] sc0, sc1;
    logic [3:0]  sc2;

    int   sel = 0;
    exp_t sb_q[$];
    int   vectors = 0;
    int   miscompares = 0;

    always #5 clk = ~clk;

    // Instance 0 uses the default configuration. Instance 1 uses
    // MEM_LATENCY = 1. Instance 2 uses a 4-bit performance counter. Only the
    // selected instance is out of reset at any time.
    pipe_stall_ctrl #(.MEM_LATENCY(5), .CNT_W(8), .PERF_W(32)) u_dut0 (
        .clk(clk), .reset(rst_v[0]), .icache_miss(icm), .dcache_miss(dcm),
        .load_use(lu), .branch_taken(bt), .wr_pc(wr_pc[0]), .wr_fd(wr_fd[0]),
        .wr_de(wr_de[0]), .wr_em(wr_em[0]), .wr_mw(wr_mw[0]),
        .flush_fd(flush_fd[0]), .bubble_de(bubble_de[0]), .mem_req(mem_req[0]),
        .mem_is_data(mem_is_data[0]), .fill_done(fill_done[0]), .stall_cycles(sc0));

    pipe_stall_ctrl #(.MEM_LATENCY(1), .CNT_W(8), .PERF_W(32)) u_dut1 (
        .clk(clk), .reset(rst_v[1]), .icache_miss(icm), .dcache_miss(dcm),
        .load_use(lu), .branch_taken(bt), .wr_pc(wr_pc[1]), .wr_fd(wr_fd[1]),
        .wr_de(wr_de[1]), .wr_em(wr_em[1]), .wr_mw(wr_mw[1]),
        .flush_fd(flush_fd[1]), .bubble_de(bubble_de[1]), .mem_req(mem_req[1]),
        .mem_is_data(mem_is_data[1]), .fill_done(fill_done[1]), .stall_cycles(sc1));

    pipe_stall_ctrl #(.MEM_LATENCY(5), .CNT_W(8), .PERF_W(4)) u_dut2 (
        .clk(clk), .reset(rst_v[2]), .icache_miss(icm), .dcache_miss(dcm),
        .load_use(lu), .branch_taken(bt), .wr_pc(wr_pc[2]), .wr_fd(wr_fd[2]),
        .wr_de(wr_de[2]), .wr_em(wr_em[2]), .wr_mw(wr_mw[2]),
        .flush_fd(flush_fd[2]), .bubble_de(bubble_de[2]), .mem_req(mem_req[2]),
        .mem_is_data(mem_is_data[2]), .fill_done(fill_done[2]), .stall_cycles(sc2));

    // Monitor: pops one expectation each falling edge and compares it against
    // the instance that the expectation names.
    always @(negedge clk) begin
        if (sb_q.size() > 0) begin
            exp_t e;
            exp_t a;
            int   k;
            e = sb_q.pop_front();
            k = int'(e.d);
            a.ph  = e.ph;
            a.d   = e.d;
            a.wr  = {wr_pc[k], wr_fd[k], wr_de[k], wr_em[k], wr_mw[k]};
            a.fl  = flush_fd[k];
            a.bu  = bubble_de[k];
            a.mr  = mem_req[k];
            a.md  = mem_is_data[k];
            a.fdn = fill_done[k];
            a.sc  = (k == 0) ? sc0 : (k == 1) ? sc1 : {28'd0, sc2};
            vectors++;
            if (a !== e) begin
                miscompares++;
                $display("FAIL ph%0d vec%0d dut%0d: got wr=%b fl=%b bu=%b mr=%b md=%b fd=%b sc=%0d, required wr=%b fl=%b bu=%b mr=%b md=%b fd=%b sc=%0d",
                         e.ph, vectors, k, a.wr, a.fl, a.bu, a.mr, a.md, a.fdn, a.sc,
                         e.wr, e.fl, e.bu, e.mr, e.md, e.fdn, e.sc);
            end else begin
                $display("ok   ph%0d vec%0d dut%0d wr=%b fl=%b bu=%b mr=%b md=%b fd=%b sc=%0d",
                         e.ph, vectors, k, a.wr, a.fl, a.bu, a.mr, a.md, a.fdn, a.sc);
            end
        end
    end

    // Apply one cycle of stimulus and queue its expected response.
    task automatic step(input int ph, input logic rst, input logic ic, input logic dc,
                        input logic l, input logic b, input logic [4:0] wr,
                        input logic fl, input logic bu, input logic mr, input logic md,
                        input logic fdn, input int sc);
        exp_t e;
        rst_v      = 3'b000;
        rst_v[sel] = rst;
        icm = ic; dcm = dc; lu = l; bt = b;
        e.ph = 4'(ph); e.d = 2'(sel); e.wr = wr; e.fl = fl; e.bu = bu;
        e.mr = mr; e.md = md; e.fdn = fdn; e.sc = 32'(sc);
        sb_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic rst_cycle(input int ph);
        step(ph, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, FROZ, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        @(posedge clk);
        #1;

        // Phase 1: reset forces every output low even with hazards present.
        // Then ten normal cycles follow.
        sel = 0;
        rst_cycle(1);
        for (int c = 0; c < 10; c++) step(1, 1, 0, 0, 0, 0, NORM, 0, 0, 0, 0, 0, 0);

        // Phase 2: D-cache miss at cycle 3, MEM_LATENCY = 5.
        rst_cycle(2);
        for (int c = 0; c < 3; c++) step(2, 1, 0, 0, 0, 0, NORM, 0, 0, 0, 0, 0, 0);
        step(2, 1, 0, 1, 0, 0, FROZ, 0, 0, 0, 0, 0, 0);
        for (int c = 4; c <= 8; c++)
            step(2, 1, 0, 1, 0, 0, FROZ, 0, 0, 1, 1, (c == 8), c - 3);
        step(2, 1, 0, 0, 0, 0, NORM, 0, 0, 0, 0, 0, 6);
        step(2, 1, 0, 0, 0, 0, NORM, 0, 0, 0, 0, 0, 6);

        // Phase 3: I-cache miss at cycle 2. A D-cache miss rises at cycle 4
        // and is queued behind the I-cache refill.
        rst_cycle(3);
        for (int c = 0; c < 2; c++) step(3, 1, 0, 0, 0, 0, NORM, 0, 0, 0, 0, 0, 0);
        step(3, 1, 1, 0, 0, 0, FROZ, 0, 0, 0, 0, 0, 0);
        for (int c = 3; c <= 7; c++)
            step(3, 1, 1, (c >= 4), 0, 0, FROZ, 0, 0, 1, 0, (c == 7), c - 2);
        for (int c = 8; c <= 12; c++)
            step(3, 1, 0, 1, 0, 0, FROZ, 0, 0, 1, 1, (c == 12), c - 2);
        step(3, 1, 0, 0, 0, 0, NORM, 0, 0, 0, 0, 0, 11);

        // Phase 4: a branch hides load_use. Then load_use occurs alone.
        // Then simultaneous I- and D-cache misses pick the D refill.
        rst_cycle(4);
        step(4, 1, 0, 0, 0, 0, NORM, 0, 0, 0, 0, 0, 0);
        step(4, 1, 0, 0, 1, 1, NORM, 1, 1, 0, 0, 0, 0);
        step(4, 1, 0, 0, 1, 0, LDU,  0, 1, 0, 0, 0, 0);
        step(4, 1, 0, 0, 0, 0, NORM, 0, 0, 0, 0, 0, 1);
        step(4, 1, 1, 1, 0, 1, FROZ, 0, 0, 0, 0, 0, 1);
        step(4, 1, 1, 1, 0, 0, FROZ, 0, 0, 1, 1, 0, 2);

        // Phase 5: reset asserted in the middle of DSTALL aborts the refill.
        rst_cycle(5);
        step(5, 1, 0, 1, 0, 0, FROZ, 0, 0, 0, 0, 0, 0);
        step(5, 1, 0, 1, 0, 0, FROZ, 0, 0, 1, 1, 0, 1);
        step(5, 1, 0, 1, 0, 0, FROZ, 0, 0, 1, 1, 0, 2);
        step(5, 0, 0, 1, 0, 0, FROZ, 0, 0, 0, 0, 0, 0);
        step(5, 0, 0, 0, 0, 0, FROZ, 0, 0, 0, 0, 0, 0);
        step(5, 1, 0, 0, 0, 0, NORM, 0, 0, 0, 0, 0, 0);
        step(5, 1, 0, 0, 0, 0, NORM, 0, 0, 0, 0, 0, 0);

        // Phase 6: MEM_LATENCY = 1 gives two frozen cycles, with fill_done
        // in the second.
        sel = 1;
        rst_cycle(6);
        step(6, 1, 0, 0, 0, 0, NORM, 0, 0, 0, 0, 0, 0);
        step(6, 1, 1, 0, 0, 0, FROZ, 0, 0, 0, 0, 0, 0);
        step(6, 1, 1, 0, 0, 0, FROZ, 0, 0, 1, 0, 1, 1);
        step(6, 1, 0, 0, 0, 0, NORM, 0, 0, 0, 0, 0, 2);

        // Phase 7: a 4-bit performance counter saturates at 15.
        sel = 2;
        rst_cycle(7);
        for (int c = 0; c < 20; c++)
            step(7, 1, 0, 0, 1, 0, LDU, 0, 1, 0, 0, 0, (c < 15) ? c : 15);
        step(7, 1, 0, 0, 0, 0, NORM, 0, 0, 0, 0, 0, 15);
        step(7, 1, 0, 0, 0, 0, NORM, 0, 0, 0, 0, 0, 15);

        // Drain the scoreboard within a bounded number of cycles.
        for (int w = 0; w < 10 && sb_q.size() > 0; w++) @(posedge clk);
        if (sb_q.size() > 0) begin
            miscompares++;
            $display("FAIL drain: %0d expectations left, required 0", sb_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/pipe_stall_ctrl.md
Name: pipe_stall_ctrl

Overview:
Central pipeline control stage that drives the write enables (wr) and bubble/flush selects of every pipeline register. The pipeline registers are write-enabled flip-flops: PC, F/D, D/E, E/M and M/W. It arbitrates I-cache misses, D-cache misses, load-use hazards and taken branches. It times memory refills with a latency counter and keeps a stall-cycle performance counter. It sits directly upstream of the pipeline register bank and feeds its wr inputs.

Parameters:
MEM_LATENCY, 5, refill cycles per cache miss (legal range 1..255)
CNT_W, 8, width of the internal latency counter (must hold MEM_LATENCY-1)
PERF_W, 32, width of the stall-cycle performance counter

Ports:
clk  input  1  pipeline clock, rising edge
reset  input  1  asynchronous, active-low reset
icache_miss  input  1  F-stage fetch missed; held until fill_done
dcache_miss  input  1  M-stage access missed; held until fill_done
load_use  input  1  D-stage instruction needs the result of a load now in E
branch_taken  input  1  E-stage branch/jump resolved taken
wr_pc  output  1  PC register write enable
wr_fd  output  1  F/D register write enable
wr_de  output  1  D/E register write enable
wr_em  output  1  E/M register write enable
wr_mw  output  1  M/W register write enable
flush_fd  output  1  F/D loads NOP instead of fetched instruction
bubble_de  output  1  D/E loads NOP instead of decoded instruction
mem_req  output  1  memory refill in progress
mem_is_data  output  1  current refill is for D-cache (0 = I-cache)
fill_done  output  1  one-cycle pulse: refill complete, cache may drop miss
stall_cycles  output  PERF_W  count of cycles with wr_pc=0 since reset

Behaviour:
- Reset (reset=0, asynchronous): state RUN, counter 0, pend_d 0, stall_cycles 0. While reset=0, every output is forced to 0 regardless of inputs.
- States: RUN, ISTALL, DSTALL. Outputs are Mealy: RUN outputs react combinationally to the inputs in the same cycle.
- RUN priority, highest first: dcache_miss > icache_miss > branch_taken > load_use > normal.
  - dcache_miss: all wr_*=0. Next state DSTALL, cnt<=MEM_LATENCY-1.
  - icache_miss, no dcache_miss: all wr_*=0. Next state ISTALL, cnt<=MEM_LATENCY-1.
  - branch_taken: all wr_*=1, flush_fd=1, bubble_de=1. A simultaneous load_use is ignored because the younger instruction is squashed.
  - load_use: wr_pc=0, wr_fd=0, wr_de=1 with bubble_de=1, wr_em=1, wr_mw=1.
  - normal: all wr_*=1, flush_fd=0, bubble_de=0.
- ISTALL/DSTALL:
  - All wr_*=0, flush_fd=0, bubble_de=0, mem_req=1. mem_is_data=1 only in DSTALL.
  - cnt decrements by 1 each cycle. In the cycle with cnt==0, fill_done=1.
  - Exit: DSTALL exits to RUN. ISTALL exits to DSTALL (cnt reloaded) if pend_d=1, else to RUN.
- A miss accepted in RUN at cycle t freezes the pipeline in cycles t..t+MEM_LATENCY: exactly MEM_LATENCY+1 frozen cycles, fill_done at t+MEM_LATENCY.
- MEM_LATENCY=1: one stall-state cycle, and fill_done fires in that first stall cycle.
- pend_d: set when dcache_miss=1 during ISTALL; cleared on entering DSTALL or on reset. icache_miss during DSTALL is not latched; it is still held by the cache and taken in RUN.
- In RUN in the cycle immediately after fill_done, the satisfied miss input is already low. Any miss still high there is treated as a new miss.
- stall_cycles: +1 on each rising edge where reset=1 and wr_pc=0. Saturates at all-ones with no wrap.
- Reset asserted mid-stall aborts the refill immediately: fill_done is not pulsed and pend_d is lost.

Test Plan:
- Reset release, all hazard inputs 0 for 10 cycles -> all wr_*=1, flush_fd=bubble_de=0, stall_cycles=0.
- RUN, dcache_miss=1 at cycle 3, held until fill_done, MEM_LATENCY=5 -> wr_*=0 in cycles 3..8, mem_req=1 and mem_is_data=1 in 4..8, fill_done only at 8, RUN at 9, stall_cycles=6.
- icache_miss at cycle 2; dcache_miss rises at cycle 4 -> ISTALL 3..7 with fill_done at 7, then DSTALL 8..12 with fill_done at 12, RUN at 13, stall_cycles=11.
- branch_taken=1 and load_use=1 in the same RUN cycle -> wr_*=1, flush_fd=1, bubble_de=1; next cycle with load_use=1 alone -> wr_pc=wr_fd=0, bubble_de=1, wr_de=wr_em=wr_mw=1, stall_cycles +1.
- MEM_LATENCY=1, icache_miss pulse -> 2 frozen cycles, fill_done in the second; reset=0 asserted mid-DSTALL (MEM_LATENCY=5) -> outputs 0 immediately, no fill_done, RUN with stall_cycles=0 after release.
- PERF_W=4, continuous load_use for 20 cycles -> stall_cycles saturates at 15 and stays 15.
